link_hang_scheduler: RTL and testbench
======================================

Name: link_hang_scheduler

Overview:
- Central scheduler for the per-link hang injectors in the simulation NoC.
- Each injector requests permission before entering its hang state. This block grants permission round-robin and caps the number of links hanging at once.
- Enforces a minimum gap between grants and force-releases any hang that overruns a watchdog limit.
- Sits in the simulation top beside the routers; one instance serves N injector ports.

Parameters:
- N, 4, number of injector ports (2..32).
- MAX_ACTIVE, 1, maximum simultaneously granted hangs (1..N).
- COOLDOWN, 0, minimum idle cycles after a grant before the next grant (0 = back-to-back).
- MAX_HANG, 1024, watchdog limit in cycles for one grant (≥1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  global enable for new grants.
- req_i  in  N  per-port hang request, level; held until granted or withdrawn.
- done_i  in  N  per-port hang-finished pulse.
- gnt_o  out  N  one-cycle grant pulse, at most one bit set.
- active_o  out  N  port currently holds a grant.
- abort_o  out  N  one-cycle watchdog force-release pulse.
- active_cnt_o  out  $clog2(N+1)  popcount of active_o.
- timeout_o  out  1  sticky: any watchdog abort since reset.
- grant_total_o  out  32  total grants issued, saturates at 2^32-1.

Behaviour:
- Reset (async, rst_ni low):
  - gnt_o, active_o, abort_o, active_cnt_o, timeout_o, grant_total_o = 0.
  - RR pointer = 0; cooldown counter = 0; all watchdog counters = 0.
  - Reset mid-hang drops all grants immediately; no abort pulses are produced.
- Per-port states:
  - IDLE→ACTIVE on grant.
  - ACTIVE→IDLE on done_i[k] or watchdog expiry.
- Eligibility of port k in cycle t: req_i[k] && !active_o[k] && en_i && active_cnt_o < MAX_ACTIVE && cooldown == 0.
- Arbitration:
  - Search eligible ports starting at the RR pointer, wrapping at N-1→0; the first hit k wins.
  - At the next edge: gnt_o[k]=1 for one cycle, active_o[k]=1, pointer←(k+1) mod N, cooldown←COOLDOWN, watchdog[k]←0, grant_total_o increments unless saturated.
  - Latency: req sampled at edge t, grant visible after edge t. Exactly one grant per cycle maximum.
- Cooldown:
  - Decrements by 1 each cycle while nonzero; no grants while nonzero.
  - COOLDOWN=0 allows a grant every cycle.
- Release:
  - done_i[k] while active_o[k]: active_o[k] clears at the next edge, making the slot usable from the following cycle.
  - done_i[k] while idle is ignored.
  - active_cnt_o is registered and reflects active_o of the same cycle.
- Simultaneous events:
  - Grant to port j and done on port k≠j in the same cycle: both take effect.
  - Eligibility uses the pre-edge active count, so a slot freed this cycle is not reused this cycle.
  - req_i dropped before grant: no grant, no state change.
- Watchdog:
  - watchdog[k] increments each cycle while active_o[k].
  - When watchdog[k] == MAX_HANG-1 and done_i[k] is low: at the next edge clear active_o[k], pulse abort_o[k] for one cycle, set timeout_o.
  - done_i[k] in that same cycle takes priority: normal release, no abort.
- en_i low: blocks new grants only. Active hangs, cooldown and watchdogs continue.
- Invariants (assert in bench): onehot0(gnt_o); popcount(active_o) ≤ MAX_ACTIVE; gnt_o & prior active_o == 0.

Test Plan (N=4, MAX_ACTIVE=2, COOLDOWN=3, MAX_HANG=100 unless stated):
- Reset, then all four req_i high, no done → gnts to ports 0, then 1 four cycles later; no further grants; active_cnt_o=2; at cycle 100 of port 0's hang abort_o[0] pulses and timeout_o=1.
- done_i[0] pulse 10 cycles after port 0's grant, req 2,3 held → next grant goes to port 2 (pointer at 2), not port 0.
- COOLDOWN=0, MAX_ACTIVE=4, req=4'b1111 → grants on four consecutive cycles, ports 0,1,2,3; grant_total_o=4.
- en_i low while req_i[1] high for 50 cycles → no grant. en_i high at cycle 50 → gnt_o[1] one cycle later.
- done_i[0] asserted exactly in port 0's watchdog cycle 99 → active_o[0] clears, abort_o=0, timeout_o stays 0.
- rst_ni pulsed low asynchronously mid-clock while two ports are active → all outputs 0 immediately; first post-reset grant goes to the lowest requesting port.

Source files
------------

// File: rtl/link_hang_scheduler_if.sv
// Injector-side bundle for the hang scheduler: request/done in, grant/active/abort status out.
// The scheduler drives the slave side; injectors and the simulation top drive the master side.
interface link_hang_scheduler_if #(
    parameter int N = 4
);
    localparam int CW = $clog2(N + 1);

    logic          en_i;
    logic [N-1:0]  req_i;
    logic [N-1:0]  done_i;
    logic [N-1:0]  gnt_o;
    logic [N-1:0]  active_o;
    logic [N-1:0]  abort_o;
    logic [CW-1:0] active_cnt_o;
    logic          timeout_o;
    logic [31:0]   grant_total_o;

    modport master (
        output en_i, req_i, done_i,
        input  gnt_o, active_o, abort_o, active_cnt_o, timeout_o, grant_total_o
    );

    modport slave (
        input  en_i, req_i, done_i,
        output gnt_o, active_o, abort_o, active_cnt_o, timeout_o, grant_total_o
    );
endinterface

// File: rtl/link_hang_scheduler.sv
// Round-robin hang-permission scheduler with active cap, grant cooldown and per-port watchdog.
// Grant one cycle after the request is sampled; requests simply wait (level-held) while blocked.
module link_hang_scheduler #(
    parameter int N          = 4,
    parameter int MAX_ACTIVE = 1,
    parameter int COOLDOWN   = 0,
    parameter int MAX_HANG   = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    link_hang_scheduler_if.slave    sch
);
    localparam int CW  = $clog2(N + 1);
    localparam int PW  = $clog2(N);
    localparam int CLW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int WW  = $clog2(MAX_HANG + 1);

    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   active_q, active_d;
    logic [N-1:0]   abort_q, abort_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           timeout_q, timeout_d;
    logic [31:0]    total_q, total_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [CLW-1:0] cool_q, cool_d;
    logic [WW-1:0]  wd_q [N];
    logic [WW-1:0]  wd_d [N];

    logic           slot_ok;
    logic [N-1:0]   elig;
    logic [N-1:0]   rel;
    logic [N-1:0]   expire;
    logic           hit;
    logic [PW-1:0]  win;
    int             j;

    always_comb begin
        // Cap uses the pre-edge count, so a slot freed this cycle is reusable only next cycle.
        slot_ok = sch.en_i && (cnt_q < CW'(MAX_ACTIVE)) && (cool_q == '0);
        elig    = sch.req_i & ~active_q & {N{slot_ok}};

        hit = 1'b0;
        win = '0;
        j   = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (!hit && elig[j]) begin
                hit = 1'b1;
                win = PW'(j);
            end
        end

        gnt_d = '0;
        if (hit) gnt_d[win] = 1'b1;

        rel = sch.done_i & active_q;
        for (int k = 0; k < N; k++) begin
            // A done in the final watchdog cycle wins over the abort.
            expire[k] = active_q[k] && !sch.done_i[k] && (wd_q[k] == WW'(MAX_HANG - 1));
        end

        active_d  = (active_q & ~rel & ~expire) | gnt_d;
        abort_d   = expire;
        cnt_d     = CW'($countones(active_d));
        timeout_d = timeout_q | (|expire);
        total_d   = (hit && (total_q != '1)) ? total_q + 32'd1 : total_q;
        ptr_d     = hit ? ((win == PW'(N - 1)) ? '0 : win + 1'b1) : ptr_q;

        if (hit)               cool_d = CLW'(COOLDOWN);
        else if (cool_q != '0) cool_d = cool_q - 1'b1;
        else                   cool_d = cool_q;

        for (int k = 0; k < N; k++) begin
            wd_d[k] = wd_q[k];
            if (gnt_d[k])         wd_d[k] = '0;
            else if (active_q[k]) wd_d[k] = wd_q[k] + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q     <= '0;
            active_q  <= '0;
            abort_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            total_q   <= '0;
            ptr_q     <= '0;
            cool_q    <= '0;
            for (int k = 0; k < N; k++) wd_q[k] <= '0;
        end else begin
            gnt_q     <= gnt_d;
            active_q  <= active_d;
            abort_q   <= abort_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            total_q   <= total_d;
            ptr_q     <= ptr_d;
            cool_q    <= cool_d;
            for (int k = 0; k < N; k++) wd_q[k] <= wd_d[k];
        end
    end

    assign sch.gnt_o         = gnt_q;
    assign sch.active_o      = active_q;
    assign sch.abort_o       = abort_q;
    assign sch.active_cnt_o  = cnt_q;
    assign sch.timeout_o     = timeout_q;
    assign sch.grant_total_o = total_q;
endmodule

// File: tb/tb_link_hang_scheduler.sv
// Bench for link_hang_scheduler: vector table on a back-to-back instance, hand sequences on a capped one.
module tb_link_hang_scheduler;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    link_hang_scheduler_if #(.N(4)) ia ();
    link_hang_scheduler_if #(.N(4)) ib ();

    link_hang_scheduler #(.N(4), .MAX_ACTIVE(2), .COOLDOWN(3), .MAX_HANG(100)) dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .sch   (ia)
    );

    link_hang_scheduler #(.N(4), .MAX_ACTIVE(4), .COOLDOWN(0), .MAX_HANG(100)) dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .sch   (ib)
    );

    typedef struct {
        logic        en;
        logic [3:0]  req;
        logic [3:0]  done;
        logic [3:0]  gnt;
        logic [3:0]  active;
        logic [2:0]  cnt;
        logic [31:0] total;
    } vec_t;

    vec_t vecs [12];
    vec_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Invariants on both instances, sampled on the falling edge.
    logic [3:0] prev_act_a, prev_act_b;
    initial begin
        prev_act_a = '0;
        prev_act_b = '0;
    end
    always @(negedge clk) begin
        if (rst_n) begin
            check("inv_a_onehot", 32'($onehot0(ia.gnt_o)), 32'd1);
            check("inv_b_onehot", 32'($onehot0(ib.gnt_o)), 32'd1);
            check("inv_a_cap", 32'($countones(ia.active_o) <= 2), 32'd1);
            check("inv_a_gnt_vs_prev", 32'(ia.gnt_o & prev_act_a), 32'd0);
            check("inv_b_gnt_vs_prev", 32'(ib.gnt_o & prev_act_b), 32'd0);
        end
        prev_act_a = ia.active_o;
        prev_act_b = ib.active_o;
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        ia.en_i   = 1'b0;
        ia.req_i  = '0;
        ia.done_i = '0;
        ib.en_i   = 1'b0;
        ib.req_i  = '0;
        ib.done_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt_a(output logic [3:0] g);
        g = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ia.gnt_o != '0) begin
                g = ia.gnt_o;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        vec_t e;
        logic [3:0] g;
        int extra;
        checks   = 0;
        failures = 0;

        //          en    req      done     gnt      active   cnt   total
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 3'd1, 32'd1};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 4'b0011, 3'd2, 32'd2};
        vecs[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 4'b0111, 3'd3, 32'd3};
        vecs[3]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 4'b1111, 3'd4, 32'd4};
        vecs[4]  = '{1'b1, 4'b1111, 4'b0001, 4'b0000, 4'b1110, 3'd3, 32'd4};
        vecs[5]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b1111, 3'd4, 32'd5};
        vecs[6]  = '{1'b1, 4'b0000, 4'b0110, 4'b0000, 4'b1001, 3'd2, 32'd5};
        vecs[7]  = '{1'b0, 4'b0110, 4'b1000, 4'b0000, 4'b0001, 3'd1, 32'd5};
        vecs[8]  = '{1'b1, 4'b0110, 4'b0001, 4'b0010, 4'b0010, 3'd1, 32'd6};
        vecs[9]  = '{1'b1, 4'b0100, 4'b0010, 4'b0100, 4'b0100, 3'd1, 32'd7};
        vecs[10] = '{1'b1, 4'b0000, 4'b1000, 4'b0000, 4'b0100, 3'd1, 32'd7};
        vecs[11] = '{1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 3'd0, 32'd7};

        do_reset();
        check("rst_b_gnt",     32'(ib.gnt_o), 32'd0);
        check("rst_b_active",  32'(ib.active_o), 32'd0);
        check("rst_b_cnt",     32'(ib.active_cnt_o), 32'd0);
        check("rst_b_total",   ib.grant_total_o, 32'd0);
        check("rst_b_timeout", 32'(ib.timeout_o), 32'd0);

        for (int i = 0; i < 12; i++) begin
            ib.en_i   = vecs[i].en;
            ib.req_i  = vecs[i].req;
            ib.done_i = vecs[i].done;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("vec%0d_gnt", i),    32'(ib.gnt_o), 32'(e.gnt));
            check($sformatf("vec%0d_active", i), 32'(ib.active_o), 32'(e.active));
            check($sformatf("vec%0d_cnt", i),    32'(ib.active_cnt_o), 32'(e.cnt));
            check($sformatf("vec%0d_total", i),  ib.grant_total_o, e.total);
            check($sformatf("vec%0d_abort", i),  32'(ib.abort_o), 32'd0);
        end
        ib.en_i = 1'b0; ib.req_i = '0; ib.done_i = '0;

        // All four requesting: cap of two, cooldown spacing, watchdog abort at cycle 100.
        do_reset();
        check("rst_a_gnt",     32'(ia.gnt_o), 32'd0);
        check("rst_a_active",  32'(ia.active_o), 32'd0);
        check("rst_a_abort",   32'(ia.abort_o), 32'd0);
        check("rst_a_timeout", 32'(ia.timeout_o), 32'd0);
        ia.en_i  = 1'b1;
        ia.req_i = 4'b1111;
        wait_gnt_a(g);
        check("s1_first_gnt", 32'(g), 32'b0001);
        extra = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 4) check("s1_second_gnt", 32'(ia.gnt_o), 32'b0010);
            else if (c < 100 && ia.gnt_o != '0) extra++;
            if (c < 100 && ia.abort_o != '0) extra++;
            if (c == 50) check("s1_cnt_capped", 32'(ia.active_cnt_o), 32'd2);
            if (c == 99) check("s1_timeout_pre", 32'(ia.timeout_o), 32'd0);
        end
        check("s1_no_extra_events", 32'(extra), 32'd0);
        check("s1_abort0",          32'(ia.abort_o), 32'b0001);
        check("s1_timeout",         32'(ia.timeout_o), 32'd1);
        check("s1_active0_clear",   32'(ia.active_o[0]), 32'd0);

        // Early done on port 0: pointer already at 2, so port 2 wins over port 0.
        do_reset();
        ia.en_i  = 1'b1;
        ia.req_i = 4'b1111;
        wait_gnt_a(g);
        check("s2_first_gnt", 32'(g), 32'b0001);
        repeat (10) @(negedge clk);
        ia.done_i = 4'b0001;
        @(negedge clk);
        ia.done_i = '0;
        check("s2_released",     32'(ia.active_o), 32'b0010);
        check("s2_cnt_released", 32'(ia.active_cnt_o), 32'd1);
        check("s2_no_same_edge", 32'(ia.gnt_o), 32'd0);
        wait_gnt_a(g);
        check("s2_next_gnt_port2", 32'(g), 32'b0100);

        // Enable held low blocks grants; grant follows one cycle after enable rises.
        do_reset();
        ia.req_i = 4'b0010;
        extra = 0;
        repeat (50) begin
            @(negedge clk);
            if (ia.gnt_o != '0) extra++;
        end
        check("s3_no_gnt_disabled", 32'(extra), 32'd0);
        ia.en_i = 1'b1;
        @(negedge clk);
        check("s3_gnt1", 32'(ia.gnt_o), 32'b0010);

        // Done in the last watchdog cycle takes priority over the abort.
        do_reset();
        ia.en_i  = 1'b1;
        ia.req_i = 4'b0001;
        wait_gnt_a(g);
        check("s4_gnt0", 32'(g), 32'b0001);
        ia.req_i = '0;
        extra = 0;
        for (int c = 1; c <= 99; c++) begin
            @(negedge clk);
            if (ia.abort_o != '0) extra++;
        end
        check("s4_active_at_99", 32'(ia.active_o), 32'b0001);
        ia.done_i = 4'b0001;
        @(negedge clk);
        ia.done_i = '0;
        check("s4_active_clear", 32'(ia.active_o), 32'd0);
        check("s4_no_abort",     32'(ia.abort_o), 32'd0);
        check("s4_no_timeout",   32'(ia.timeout_o), 32'd0);
        @(negedge clk);
        check("s4_no_late_abort", 32'(extra) + 32'(ia.abort_o), 32'd0);

        // Asynchronous reset mid-cycle with two hangs active.
        do_reset();
        ia.en_i  = 1'b1;
        ia.req_i = 4'b1111;
        wait_gnt_a(g);
        repeat (4) @(negedge clk);
        check("s5_two_active", 32'(ia.active_cnt_o), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_flags", 32'({ia.gnt_o, ia.active_o, ia.abort_o, ia.active_cnt_o, ia.timeout_o}), 32'd0);
        check("s5_rst_total", ia.grant_total_o, 32'd0);
        ia.req_i = 4'b1100;
        @(negedge clk);
        rst_n = 1'b1;
        wait_gnt_a(g);
        check("s5_post_rst_gnt", 32'(g), 32'b0100);

        ia.en_i = 1'b0; ia.req_i = '0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
